// File: rtl/morse_recorder.sv
// ---------------------------------------------------------------------------
// morse_recorder
//   Morse front-end timing recorder. Counts the length, in clock cycles, of
//   successive high pulses on the key input and stores up to NUM_SLOTS of them.
//   The message ends when a low gap reaches GAP_MAX cycles or every slot has
//   been filled. After that the recorder freezes with m_end high until reset.
//
// Ports
//   clk     in   rising-edge clock
//   sig_in  in   raw key signal, asynchronous to clk
//   reset   in   synchronous, active-high; clears all state
//   m_end   out  message ended; level, held until reset
//   valid   out  one-cycle pulse in the cycle a slot is written
//
// Internal state read by the symbol decoder
//   value           slot i lives at bits [i*WID +: WID]
//   decoded_sig_ct  bit i set once slot i has been written
// ---------------------------------------------------------------------------
module morse_recorder #(
    parameter int WID       = 32,
    parameter int NUM_SLOTS = 5,
    parameter int GAP_MAX   = 25
) (
    input  logic clk,
    input  logic sig_in,
    input  logic reset,
    output logic m_end,
    output logic valid
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t                     state;
    logic                       sig_s;
    logic [WID-1:0]             hi_cnt;
    logic [WID-1:0]             lo_cnt;
    logic [SLOT_W-1:0]          slot;
    logic [NUM_SLOTS*WID-1:0]   value;
    logic [NUM_SLOTS-1:0]       decoded_sig_ct;

    // Pulse lengths saturate at all-ones instead of wrapping to a short value.
    function automatic logic [WID-1:0] sat_inc(input logic [WID-1:0] x);
        return (x == {WID{1'b1}}) ? x : x + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sig_s          <= 1'b0;
            hi_cnt         <= '0;
            lo_cnt         <= '0;
            slot           <= '0;
            value          <= '0;
            decoded_sig_ct <= '0;
            m_end          <= 1'b0;
            valid          <= 1'b0;
        end else begin
            // Input synchroniser stage: every decision below looks at sig_s.
            sig_s <= sig_in;
            valid <= 1'b0;

            case (state)
                // Leading low time before the first key-down is not recorded.
                IDLE: begin
                    if (sig_s) begin
                        state  <= HIGH;
                        hi_cnt <= WID'(1);
                    end
                end

                HIGH: begin
                    if (sig_s) begin
                        hi_cnt <= sat_inc(hi_cnt);
                    end else begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (slot == SLOT_W'(i)) begin
                                value[i*WID +: WID] <= hi_cnt;
                                decoded_sig_ct[i]   <= 1'b1;
                            end
                        end
                        valid <= 1'b1;
                        slot  <= slot + 1'b1;
                        if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
                            state <= DONE;
                            m_end <= 1'b1;
                        end else begin
                            // The falling-edge cycle is the first low cycle of the gap.
                            state  <= LOW;
                            lo_cnt <= WID'(1);
                        end
                    end
                end

                LOW: begin
                    if (sig_s) begin
                        state  <= HIGH;
                        hi_cnt <= WID'(1);
                    end else begin
                        lo_cnt <= lo_cnt + 1'b1;
                        if (lo_cnt + 1'b1 == WID'(GAP_MAX)) begin
                            state <= DONE;
                            m_end <= 1'b1;
                        end
                    end
                end

                // Frozen: key input ignored, slots held until reset.
                DONE: begin
                    m_end <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_recorder.sv
module tb_morse_recorder;

    localparam int WID       = 32;
    localparam int NUM_SLOTS = 5;
    localparam int GAP_MAX   = 25;
    localparam int MAXL      = 2048;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sig_in = 1'b0;
    logic m_end;
    logic valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus: one sig_in level per clock cycle.
    bit stim[$];

    // Reference model results, indexed by edge number within a sequence.
    logic                 exp_valid [MAXL];
    logic                 exp_mend  [MAXL];
    int                   exp_slot  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] exp_mask;

    morse_recorder #(
        .WID      (WID),
        .NUM_SLOTS(NUM_SLOTS),
        .GAP_MAX  (GAP_MAX)
    ) dut (
        .clk   (clk),
        .sig_in(sig_in),
        .reset (reset),
        .m_end (m_end),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic add(input bit lvl, input int n);
        repeat (n) stim.push_back(lvl);
    endtask

    // Behavioural model: parse the level sequence into high runs and low gaps.
    // The input flop delays everything by one edge, so a high run ending at
    // index b is written on edge b+2 and a gap starting at index g ends the
    // message on edge g+GAP_MAX.
    task automatic build_model();
        int len_s;
        int i;
        int a;
        int ls;
        int wr;
        int nslot;
        int end_edge;
        len_s = stim.size();
        for (int k = 0; k < MAXL; k++) begin
            exp_valid[k] = 1'b0;
            exp_mend[k]  = 1'b0;
        end
        for (int k = 0; k < NUM_SLOTS; k++) exp_slot[k] = 0;
        exp_mask = '0;
        nslot    = 0;
        end_edge = -1;
        i = 0;
        while (i < len_s && !stim[i]) i++;
        while (i < len_s) begin
            a = i;
            while (i < len_s && stim[i]) i++;
            if (i >= len_s) break;
            exp_slot[nslot] = i - a;
            exp_mask[nslot] = 1'b1;
            wr = i + 1;
            if (wr < MAXL) exp_valid[wr] = 1'b1;
            nslot++;
            if (nslot == NUM_SLOTS) begin
                end_edge = wr;
                break;
            end
            ls = i;
            while (i < len_s && !stim[i]) i++;
            if (i - ls >= GAP_MAX) begin
                end_edge = ls + GAP_MAX;
                break;
            end
        end
        if (end_edge >= 0)
            for (int k = end_edge; k < MAXL; k++) exp_mend[k] = 1'b1;
    endtask

    task automatic check_slots(input string name);
        logic [WID-1:0] got;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            got = dut.value[s*WID +: WID];
            n_cmp++;
            if (got !== WID'(exp_slot[s])) begin
                n_bad++;
                $display("FAIL %s slot%0d: got %0d expected %0d", name, s, got, exp_slot[s]);
            end
        end
        n_cmp++;
        if (dut.decoded_sig_ct !== exp_mask) begin
            n_bad++;
            $display("FAIL %s decoded_sig_ct: got %b expected %b", name, dut.decoded_sig_ct, exp_mask);
        end
    endtask

    // Drive the queued stimulus, checking valid and m_end every cycle,
    // then the stored slots.
    task automatic run_seq(input string name);
        build_model();
        for (int k = 0; k < stim.size(); k++) begin
            sig_in = stim[k];
            @(posedge clk);
            #1;
            n_cmp++;
            if (valid !== exp_valid[k]) begin
                n_bad++;
                $display("FAIL %s valid@%0d: got %b expected %b", name, k, valid, exp_valid[k]);
            end
            n_cmp++;
            if (m_end !== exp_mend[k]) begin
                n_bad++;
                $display("FAIL %s m_end@%0d: got %b expected %b", name, k, m_end, exp_mend[k]);
            end
        end
        check_slots(name);
        stim.delete();
    endtask

    task automatic do_reset(input logic lvl, input string name);
        sig_in = lvl;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (m_end !== 1'b0) begin
            n_bad++;
            $display("FAIL %s reset m_end: got %b expected 0", name, m_end);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s reset valid: got %b expected 0", name, valid);
        end
        n_cmp++;
        if (dut.value !== '0) begin
            n_bad++;
            $display("FAIL %s reset value: got %h expected 0", name, dut.value);
        end
        n_cmp++;
        if (dut.decoded_sig_ct !== '0) begin
            n_bad++;
            $display("FAIL %s reset decoded_sig_ct: got %b expected 0", name, dut.decoded_sig_ct);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0, "reset");
        add(1'b0, 100);
        run_seq("idle_low");
    endtask

    task automatic test_five_pulses();
        int highs [5] = '{13, 14, 18, 15, 18};
        add(1'b0, 3);
        for (int p = 0; p < 5; p++) begin
            add(1'b1, highs[p]);
            add(1'b0, 10);
        end
        add(1'b0, 20);
        run_seq("five_pulses");
    endtask

    task automatic test_reset_then_gap();
        do_reset(1'b0, "reset_after_full");
        add(1'b1, 13); add(1'b0, 10);
        add(1'b1, 18); add(1'b0, 10);
        add(1'b1, 14); add(1'b0, 35);
        run_seq("gap_end");
    endtask

    task automatic test_gap_boundary();
        do_reset(1'b0, "reset_gap");
        add(1'b0, 2);
        add(1'b1, 4);  add(1'b0, GAP_MAX - 1);
        add(1'b1, 3);  add(1'b0, GAP_MAX);
        add(1'b1, 5);  add(1'b0, 10);
        run_seq("gap_boundary");
    endtask

    task automatic test_done_ignores();
        // Recorder is in DONE from the previous scenario; exp_* still hold its result.
        for (int k = 0; k < 20; k++) begin
            sig_in = (k % 2 == 0);
            @(posedge clk);
            #1;
            n_cmp++;
            if (valid !== 1'b0) begin
                n_bad++;
                $display("FAIL done_toggle valid@%0d: got %b expected 0", k, valid);
            end
            n_cmp++;
            if (m_end !== 1'b1) begin
                n_bad++;
                $display("FAIL done_toggle m_end@%0d: got %b expected 1", k, m_end);
            end
        end
        check_slots("done_toggle");
    endtask

    task automatic test_reset_mid_pulse();
        do_reset(1'b0, "reset_pre_mid");
        add(1'b0, 3);
        add(1'b1, 10);
        run_seq("mid_pulse_pre");
        do_reset(1'b1, "reset_mid_pulse");
        add(1'b1, 7);
        add(1'b0, 30);
        run_seq("mid_pulse_post");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset(1'b0, "reset_rand");
            add(1'b0, $urandom_range(0, 5));
            for (int p = 0; p < 6; p++) begin
                add(1'b1, $urandom_range(1, 20));
                if ($urandom_range(0, 3) == 0)
                    add(1'b0, $urandom_range(GAP_MAX - 1, GAP_MAX + 5));
                else
                    add(1'b0, $urandom_range(1, GAP_MAX - 1));
            end
            add(1'b0, 40);
            run_seq("random");
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_five_pulses();
        test_reset_then_gap();
        test_done_ignores();
        test_gap_boundary();
        test_reset_mid_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
